// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection with branch-flush priority for a 5-stage pipeline.
// Issues LOAD_STALLS bubble cycles per load-use hazard and counts stalls/flushes.
module hazard_detection_unit #(
  parameter int LOAD_STALLS = 1,
  parameter int CW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    IF_ID_Rn,
  input  logic [4:0]    IF_ID_Rm,
  input  logic          IF_ID_useRm,
  input  logic          ID_EX_memRead,
  input  logic [4:0]    ID_EX_Rd,
  input  logic          MEM_PCSrc,
  output logic          PCWrite,
  output logic          IF_ID_write,
  output logic          ID_EX_bubble,
  output logic          flush,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [1:0]    STALL_INIT  = 2'(LOAD_STALLS - 1);
  localparam logic [0:0]    STALL_ENTRY = (LOAD_STALLS > 1) ? STALL : RUN;
  localparam logic [4:0]    XZR         = 5'd31;
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE     = CW'(1'b1);

  // XZR is hard-wired zero, so a load targeting it can never feed a consumer.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rn,
    input logic [4:0] rm,
    input logic       use_rm
  );
    logic hit;
    hit = (rd == rn) || (use_rm && (rd == rm));
    return mem_read && (rd != XZR) && hit;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_ONE;
  endfunction

  logic [0:0]    state_r;
  logic [0:0]    next_state_s;
  logic [1:0]    cnt_r;
  logic [1:0]    next_cnt_s;
  logic [4:0]    load_rd_r;
  logic [4:0]    next_load_rd_s;
  logic          hazard_s;
  logic          pc_write_s;
  logic          if_id_write_s;
  logic          bubble_s;
  logic          flush_s;
  logic [CW-1:0] stall_count_r;
  logic [CW-1:0] flush_count_r;

  assign hazard_s = load_use_hazard(ID_EX_memRead, ID_EX_Rd, IF_ID_Rn, IF_ID_Rm, IF_ID_useRm);

  // Next-state and zero-latency pipeline control decode.
  always_comb begin
    next_state_s   = state_r;
    next_cnt_s     = cnt_r;
    next_load_rd_s = load_rd_r;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    bubble_s       = 1'b0;
    flush_s        = 1'b0;
    if (reset) begin
      next_state_s   = RUN;
      next_cnt_s     = 2'd0;
      next_load_rd_s = 5'd0;
    end else if (MEM_PCSrc) begin
      // A taken branch squashes everything younger, including any pending stall.
      flush_s       = 1'b1;
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
      bubble_s      = 1'b1;
      next_state_s  = RUN;
      next_cnt_s    = 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (hazard_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            bubble_s       = 1'b1;
            next_cnt_s     = STALL_INIT;
            next_load_rd_s = ID_EX_Rd;
            next_state_s   = STALL_ENTRY;
          end else begin
            next_state_s = RUN;
          end
        end
        STALL: begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          bubble_s      = 1'b1;
          next_cnt_s    = cnt_r - 2'd1;
          if (cnt_r <= 2'd1) begin
            next_state_s = RUN;
          end else begin
            next_state_s = STALL;
          end
        end
        default: begin
          next_state_s = RUN;
          next_cnt_s   = 2'd0;
        end
      endcase
    end
  end

  // FSM state, remaining-stall counter and debug copy of the load destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= RUN;
      cnt_r     <= 2'd0;
      load_rd_r <= 5'd0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= next_cnt_s;
      load_rd_r <= next_load_rd_s;
    end
  end

  // Saturating performance counters; a flushed bubble is not a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= {CW{1'b0}};
      flush_count_r <= {CW{1'b0}};
    end else begin
      if (bubble_s && !flush_s) begin
        stall_count_r <= sat_inc(stall_count_r);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush_s) begin
        flush_count_r <= sat_inc(flush_count_r);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign PCWrite      = pc_write_s;
  assign IF_ID_write  = if_id_write_s;
  assign ID_EX_bubble = bubble_s;
  assign flush        = flush_s;
  assign stall_count  = stall_count_r;
  assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench: four parameterisations driven independently, expected
// control/counter values queued at stimulus time and checked mid-cycle.
module tb_hazard_detection_unit;

  typedef struct {
    int          sel;
    string       name;
    logic [3:0]  ctl;   // {PCWrite, IF_ID_write, ID_EX_bubble, flush}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [4];
  logic [4:0]  rn       [4];
  logic [4:0]  rm       [4];
  logic        use_rm   [4];
  logic        mem_read [4];
  logic [4:0]  rd       [4];
  logic        pcsrc    [4];
  logic        pcw      [4];
  logic        ifw      [4];
  logic        bub      [4];
  logic        fl       [4];
  logic [31:0] sc       [4];
  logic [31:0] fc       [4];
  logic [3:0]  sc3_w;
  logic [3:0]  fc3_w;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wait_cycles;

  // inst 0: LOAD_STALLS=1, inst 1: 2, inst 2: 3, inst 3: LOAD_STALLS=1 with CW=4
  hazard_detection_unit #(.LOAD_STALLS(1), .CW(32)) u_ls1 (
    .clk(clk), .reset(rst[0]), .IF_ID_Rn(rn[0]), .IF_ID_Rm(rm[0]), .IF_ID_useRm(use_rm[0]),
    .ID_EX_memRead(mem_read[0]), .ID_EX_Rd(rd[0]), .MEM_PCSrc(pcsrc[0]),
    .PCWrite(pcw[0]), .IF_ID_write(ifw[0]), .ID_EX_bubble(bub[0]), .flush(fl[0]),
    .stall_count(sc[0]), .flush_count(fc[0]));

  hazard_detection_unit #(.LOAD_STALLS(2), .CW(32)) u_ls2 (
    .clk(clk), .reset(rst[1]), .IF_ID_Rn(rn[1]), .IF_ID_Rm(rm[1]), .IF_ID_useRm(use_rm[1]),
    .ID_EX_memRead(mem_read[1]), .ID_EX_Rd(rd[1]), .MEM_PCSrc(pcsrc[1]),
    .PCWrite(pcw[1]), .IF_ID_write(ifw[1]), .ID_EX_bubble(bub[1]), .flush(fl[1]),
    .stall_count(sc[1]), .flush_count(fc[1]));

  hazard_detection_unit #(.LOAD_STALLS(3), .CW(32)) u_ls3 (
    .clk(clk), .reset(rst[2]), .IF_ID_Rn(rn[2]), .IF_ID_Rm(rm[2]), .IF_ID_useRm(use_rm[2]),
    .ID_EX_memRead(mem_read[2]), .ID_EX_Rd(rd[2]), .MEM_PCSrc(pcsrc[2]),
    .PCWrite(pcw[2]), .IF_ID_write(ifw[2]), .ID_EX_bubble(bub[2]), .flush(fl[2]),
    .stall_count(sc[2]), .flush_count(fc[2]));

  hazard_detection_unit #(.LOAD_STALLS(1), .CW(4)) u_cw4 (
    .clk(clk), .reset(rst[3]), .IF_ID_Rn(rn[3]), .IF_ID_Rm(rm[3]), .IF_ID_useRm(use_rm[3]),
    .ID_EX_memRead(mem_read[3]), .ID_EX_Rd(rd[3]), .MEM_PCSrc(pcsrc[3]),
    .PCWrite(pcw[3]), .IF_ID_write(ifw[3]), .ID_EX_bubble(bub[3]), .flush(fl[3]),
    .stall_count(sc3_w), .flush_count(fc3_w));

  assign sc[3] = {28'd0, sc3_w};
  assign fc[3] = {28'd0, fc3_w};

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      rn[i] = 5'd0; rm[i] = 5'd0; use_rm[i] = 1'b0;
      mem_read[i] = 1'b0; rd[i] = 5'd0; pcsrc[i] = 1'b0;
    end
  endtask

  // One clock of stimulus on instance sel, plus the response expected this cycle.
  task automatic step(input int sel, input string name, input logic r, input logic mr,
                      input logic [4:0] d, input logic [4:0] n, input logic [4:0] m,
                      input logic u, input logic pc, input logic [3:0] ctl,
                      input int esc, input int efc);
    exp_t x;
    @(posedge clk);
    #1;
    idle_all();
    rst[sel] = r; mem_read[sel] = mr; rd[sel] = d; rn[sel] = n;
    rm[sel] = m; use_rm[sel] = u; pcsrc[sel] = pc;
    x.sel = sel; x.name = name; x.ctl = ctl; x.sc = 32'(esc); x.fc = 32'(efc);
    exp_q.push_back(x);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Monitor: compare the queued expectation against the live outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({pcw[e.sel], ifw[e.sel], bub[e.sel], fl[e.sel]} !== e.ctl ||
          sc[e.sel] !== e.sc || fc[e.sel] !== e.fc) begin
        n_fail++;
        $display("FAIL %s (inst %0d): got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                 e.name, e.sel, {pcw[e.sel], ifw[e.sel], bub[e.sel], fl[e.sel]},
                 sc[e.sel], fc[e.sel], e.ctl, e.sc, e.fc);
      end
    end
  end

  initial begin
    idle_all();
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state of every instance
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({pcw[i], ifw[i], bub[i], fl[i]} !== 4'b1100 || sc[i] !== 32'd0 || fc[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_state (inst %0d): got ctl=%b stall=%0d flush=%0d, expected ctl=1100 stall=0 flush=0",
                 i, {pcw[i], ifw[i], bub[i], fl[i]}, sc[i], fc[i]);
      end
    end

    // reset overrides hazard and flush inputs
    step(0, "rst_hold_haz",   1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b1100, 0, 0);
    step(0, "rst_hold_flush", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1100, 0, 0);
    @(posedge clk);
    #1;
    idle_all();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // LOAD_STALLS=1
    step(0, "ls1_idle",      1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 0, 0);
    step(0, "ls1_haz_rn",    1'b0, 1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 4'b0010, 0, 0);
    step(0, "ls1_after",     1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 1, 0);
    step(0, "ls1_xzr",       1'b0, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 4'b1100, 1, 0);
    step(0, "ls1_xzr_after", 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 1, 0);
    step(0, "ls1_rm_unused", 1'b0, 1'b1, 5'd7,  5'd3,  5'd7, 1'b0, 1'b0, 4'b1100, 1, 0);
    step(0, "ls1_rm_used",   1'b0, 1'b1, 5'd7,  5'd3,  5'd7, 1'b1, 1'b0, 4'b0010, 1, 0);
    step(0, "ls1_rm_after",  1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 2, 0);
    step(0, "ls1_no_load",   1'b0, 1'b0, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 4'b1100, 2, 0);
    step(0, "ls1_flush",     1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 4'b1111, 2, 0);
    step(0, "ls1_flush_cnt", 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 2, 1);
    step(0, "ls1_haz_flush", 1'b0, 1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 1'b1, 4'b1111, 2, 1);
    step(0, "ls1_hf_after",  1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 2, 2);
    step(0, "ls1_b2b_a",     1'b0, 1'b1, 5'd4,  5'd4,  5'd0, 1'b0, 1'b0, 4'b0010, 2, 2);
    step(0, "ls1_b2b_b",     1'b0, 1'b1, 5'd6,  5'd0,  5'd6, 1'b1, 1'b0, 4'b0010, 3, 2);
    step(0, "ls1_b2b_after", 1'b0, 1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 4'b1100, 4, 2);

    // LOAD_STALLS=2: exact length, back-to-back, reset mid-stall
    step(1, "ls2_idle",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 0, 0);
    step(1, "ls2_haz_a",     1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 4'b0010, 0, 0);
    step(1, "ls2_stall_a",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 1, 0);
    step(1, "ls2_run_a",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 2, 0);
    step(1, "ls2_haz_b",     1'b0, 1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 4'b0010, 2, 0);
    step(1, "ls2_stall_b",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 3, 0);
    step(1, "ls2_haz_c",     1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 4'b0010, 4, 0);
    step(1, "ls2_stall_c",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 5, 0);
    step(1, "ls2_run_c",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 6, 0);
    step(1, "ls2_flush",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 6, 0);
    step(1, "ls2_flush_cnt", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 6, 1);
    step(1, "ls2_haz_d",     1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 4'b0010, 6, 1);
    step(1, "ls2_rst_stall", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 7, 1);
    step(1, "ls2_post_rst",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 0, 0);
    step(1, "ls2_haz_e",     1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 4'b0010, 0, 0);
    step(1, "ls2_stall_e",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 1, 0);
    step(1, "ls2_run_e",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 2, 0);

    // LOAD_STALLS=3: flush on the 2nd stall cycle, then a full stall
    step(2, "ls3_idle",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 0, 0);
    step(2, "ls3_haz",       1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 4'b0010, 0, 0);
    step(2, "ls3_flush_s2",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 1, 0);
    step(2, "ls3_run_1",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 1, 1);
    step(2, "ls3_run_2",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 1, 1);
    step(2, "ls3_haz_rm",    1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 4'b0010, 1, 1);
    step(2, "ls3_stall_2",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 2, 1);
    step(2, "ls3_stall_3",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b0010, 3, 1);
    step(2, "ls3_run_end",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 4, 1);

    // CW=4: both counters saturate at 15
    for (int i = 0; i < 20; i++)
      step(3, "cw4_haz", 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b0010, sat15(i), 0);
    step(3, "cw4_stall_sat", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 15, 0);
    for (int i = 0; i < 17; i++)
      step(3, "cw4_flush", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'b1111, 15, sat15(i));
    step(3, "cw4_flush_sat", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'b1100, 15, 15);

    // bounded wait for the scoreboard to drain
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations still pending after %0d cycles",
               exp_q.size(), wait_cycles);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter LOAD_STALLS, default 1, number of bubble cycles per load-use hazard (legal 1..3).
REQ-002 SHALL have parameter CW, default 32, performance-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port IF_ID_Rn  input  5  first source register of the instruction in ID.
REQ-006 SHALL have port IF_ID_Rm  input  5  second source register of the instruction in ID.
REQ-007 SHALL have port IF_ID_useRm  input  1  ID instruction reads Rm (0 for loads and immediates).
REQ-008 SHALL have port ID_EX_memRead  input  1  instruction in EX is a load.
REQ-009 SHALL have port ID_EX_Rd  input  5  destination of instruction in EX.
REQ-010 SHALL have port MEM_PCSrc  input  1  taken branch resolved in MEM this cycle.
REQ-011 SHALL have port PCWrite  output  1  PC update enable.
REQ-012 SHALL have port IF_ID_write  output  1  IF/ID register load enable.
REQ-013 SHALL have port ID_EX_bubble  output  1  zero ID/EX control signals.
REQ-014 SHALL have port flush  output  1  zero IF/ID, ID/EX and EX/MEM control signals.
REQ-015 SHALL have port stall_count  output  CW  total stall cycles issued.
REQ-016 SHALL have port flush_count  output  CW  total flush events issued.

Function
REQ-017 SHALL implement FSM states RUN and STALL, held in a state register plus a 2-bit stall counter cnt and a latched 5-bit load_rd.
REQ-018 Hazard condition SHALL be: ID_EX_memRead=1, ID_EX_Rd!=31, and (ID_EX_Rd==IF_ID_Rn or (IF_ID_useRm=1 and ID_EX_Rd==IF_ID_Rm)).
REQ-019 Register 31 (XZR) SHALL never cause a hazard.
REQ-020 In RUN with no hazard and MEM_PCSrc=0: PCWrite=1, IF_ID_write=1, ID_EX_bubble=0, flush=0; state stays RUN.
REQ-021 In RUN with hazard and MEM_PCSrc=0: same cycle PCWrite=0, IF_ID_write=0, ID_EX_bubble=1 (combinational, zero latency); cnt<=LOAD_STALLS-1, load_rd<=ID_EX_Rd; next state STALL if LOAD_STALLS>1, else RUN.
REQ-022 In STALL with MEM_PCSrc=0: PCWrite=0, IF_ID_write=0, ID_EX_bubble=1; cnt decrements; when cnt==1 next state RUN.
REQ-023 Total consecutive stall cycles per hazard SHALL equal exactly LOAD_STALLS.
REQ-024 MEM_PCSrc=1 in any state SHALL assert flush=1, PCWrite=1, IF_ID_write=1, ID_EX_bubble=1, force next state RUN, clear cnt; flush has priority over any stall.
REQ-025 A hazard coincident with MEM_PCSrc=1 SHALL be discarded (no stall issued, no stall counted).
REQ-026 stall_count SHALL increment by 1 on every cycle in which ID_EX_bubble=1 and flush=0.
REQ-027 flush_count SHALL increment by 1 on every cycle with flush=1.
REQ-028 Both counters SHALL saturate at 2^CW-1, never wrap.
REQ-029 load_rd SHALL be exposed to nothing outside; it exists only for debug visibility and SHALL not alter outputs.
REQ-030 Back-to-back loads each with a dependent consumer SHALL each generate a full LOAD_STALLS stall.

Reset
REQ-031 With reset=1 at a rising edge: state<=RUN, cnt<=0, load_rd<=0, stall_count<=0, flush_count<=0.
REQ-032 While reset=1, outputs SHALL be PCWrite=1, IF_ID_write=1, ID_EX_bubble=0, flush=0 regardless of other inputs.
REQ-033 Reset asserted mid-STALL SHALL abort the stall; first cycle after reset deassertion is RUN.

Verification
REQ-034 LOAD_STALLS=1: memRead=1, ID_EX_Rd=5, IF_ID_Rn=5 -> one cycle PCWrite=0, ID_EX_bubble=1; stall_count=1.
REQ-035 memRead=1, ID_EX_Rd=31, IF_ID_Rn=31 -> no stall, outputs RUN values, stall_count=0.
REQ-036 memRead=1, ID_EX_Rd=7, IF_ID_Rm=7, IF_ID_useRm=0 -> no stall; with useRm=1 -> stall.
REQ-037 LOAD_STALLS=3, hazard, MEM_PCSrc=1 on 2nd stall cycle -> flush=1 that cycle, RUN next, stall_count=1, flush_count=1.
REQ-038 LOAD_STALLS=2, hazard, reset=1 on 2nd stall cycle -> all counters 0, RUN outputs after reset release.
REQ-039 CW=4, 20 hazards -> stall_count holds 15.
